count_bcd_reader: RTL and testbench
===================================

COUNT_BCD_READER -- requirements
Module: count_bcd_reader

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 CLK  input  1  single system clock; all state SHALL update on the rising edge only.
REQ-003 RST  input  1  reset, synchronous and active-low, sampled on rising CLK.
REQ-004 SEL  input  1  counter direction of the sampled word: 0 = up, 1 = down.
REQ-005 CNT_IN  input  19  counter word; [17:0] magnitude, [18] wrap flag.
REQ-006 START  input  1  conversion request, level-sampled.
REQ-007 BUSY  output  1  high while a conversion is in progress or presenting its result.
REQ-008 VALID  output  1  one-cycle pulse; BCD, OVF and UNF are newly updated.
REQ-009 BCD  output  24  six packed BCD digits; [23:20] = hundred-thousands, [3:0] = units.
REQ-010 OVF  output  1  the captured word was an up-count wrap: SEL=1'b0 and CNT_IN[18]=1'b1.
REQ-011 UNF  output  1  the captured word was a down-count borrow: SEL=1'b1 and CNT_IN[18]=1'b1.

Function
REQ-012 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 IDLE: on an edge with START=1, the block SHALL capture CNT_IN[17:0], CNT_IN[18] and SEL, clear the BCD scratch register, zero the shift counter and enter SHIFT.
REQ-014 SHIFT SHALL perform one double-dabble step per edge: each scratch digit >= 5 gets +3 (mod 16), then the scratch is shifted left 1 and the magnitude MSB is shifted in, MSB first.
REQ-015 SHIFT SHALL run exactly 18 edges; on the 18th edge the final scratch value SHALL be written to BCD, OVF and UNF SHALL be written from the captured flags, and the state SHALL become DONE.
REQ-016 DONE: VALID=1 for exactly that one cycle; the next edge SHALL return the state to IDLE.
REQ-017 Timing: if the capture edge is E0, VALID SHALL be high between E18 and E19, and BUSY SHALL be high from E0 to E19 (SHIFT and DONE).
REQ-018 BUSY and VALID SHALL be registered outputs, decoded from the state.
REQ-019 START SHALL be ignored in SHIFT and DONE; no request is queued.
REQ-020 If START is held high, a new capture SHALL occur at E19, giving one result every 19 cycles.
REQ-021 Changes to CNT_IN or SEL after the capture edge SHALL NOT affect the result in progress.
REQ-022 BCD, OVF and UNF SHALL hold their last values until the next DONE entry.
REQ-023 The maximum magnitude of 262143 SHALL convert without digit overflow (BCD=24'h262143).
REQ-024 CNT_IN[18] SHALL NOT contribute to the BCD value.
REQ-025 OVF and UNF SHALL never both be 1.

Reset
REQ-026 With RST=0 at an edge, the block SHALL enter IDLE and set BUSY=0, VALID=0, BCD=24'h0, OVF=0, UNF=0, and clear the scratch register, shift counter and captured flags.
REQ-027 Reset SHALL take priority over START on the same edge, and over any SHIFT or DONE activity.
REQ-028 Reset mid-conversion SHALL abort it; no VALID pulse SHALL follow for the aborted request.
REQ-029 The first START after RST returns to 1 SHALL be accepted normally.

Verification
REQ-030 CNT_IN=19'd123456, SEL=0, one-cycle START at E0 -> BUSY high E0..E19; VALID only between E18 and E19; BCD=24'h123456, OVF=0, UNF=0.
REQ-031 CNT_IN=19'h3FFFF, SEL=1 -> BCD=24'h262143, UNF=0; then CNT_IN=19'd0 -> BCD=24'h000000.
REQ-032 CNT_IN=19'h40000 with SEL=0 -> BCD=0, OVF=1, UNF=0; then the same word with SEL=1 -> OVF=0, UNF=1.
REQ-033 START held high, CNT_IN changed to 19'd999 at E5 -> first result still the E0 value; second capture at E19 yields BCD=24'h000999.
REQ-034 Converting 19'd42, then RST=0 at the 9th SHIFT edge of a conversion of 19'd7 -> next cycle BUSY=0, VALID=0, BCD=0; no VALID pulse afterwards.
REQ-035 RST=0 and START=1 on the same edge -> IDLE, BUSY=0; a START after release gives a correct result 19 cycles later.

Source files
------------

// File: rtl/count_bcd_reader.sv
// Latches an 18-bit counter magnitude plus its wrap flag and converts the
// magnitude to six packed BCD digits with a serial double-dabble engine.
module count_bcd_reader (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sel,
    input  logic [18:0] i_cnt_in,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_valid,
    output logic [23:0] o_bcd,
    output logic        o_ovf,
    output logic        o_unf
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t      r_state, w_state_next;
    logic [17:0] r_mag, w_mag_next;
    logic        r_wrap, w_wrap_next;
    logic        r_sel, w_sel_next;
    logic [23:0] r_scratch, w_scratch_next;
    logic [4:0]  r_cnt, w_cnt_next;
    logic [23:0] r_bcd, w_bcd_next;
    logic        r_ovf, w_ovf_next;
    logic        r_unf, w_unf_next;
    logic        r_busy;
    logic        r_valid;

    logic [23:0] w_adj;
    logic [23:0] w_shifted;
    logic        w_capture;

    always_comb begin
        w_adj = '0;
        for (int i = 0; i < 6; i++) begin
            w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5) ?
                              r_scratch[4*i +: 4] + 4'd3 : r_scratch[4*i +: 4];
        end
        w_shifted = (w_adj << 1) | {23'd0, r_mag[17]};
    end

    // A START seen on the DONE exit edge starts the next conversion directly,
    // so a held START yields one result every 19 cycles.
    assign w_capture = i_start && ((r_state == StIdle) || (r_state == StDone));

    always_comb begin
        w_state_next   = r_state;
        w_mag_next     = r_mag;
        w_wrap_next    = r_wrap;
        w_sel_next     = r_sel;
        w_scratch_next = r_scratch;
        w_cnt_next     = r_cnt;
        w_bcd_next     = r_bcd;
        w_ovf_next     = r_ovf;
        w_unf_next     = r_unf;

        unique case (r_state)
            StIdle: ;
            StShift: begin
                w_scratch_next = w_shifted;
                w_mag_next     = r_mag << 1;
                w_cnt_next     = r_cnt + 5'd1;
                if (r_cnt == 5'd17) begin
                    w_bcd_next   = w_shifted;
                    w_ovf_next   = ~r_sel & r_wrap;
                    w_unf_next   = r_sel & r_wrap;
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase

        if (w_capture) begin
            w_mag_next     = i_cnt_in[17:0];
            w_wrap_next    = i_cnt_in[18];
            w_sel_next     = i_sel;
            w_scratch_next = '0;
            w_cnt_next     = '0;
            w_state_next   = StShift;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_mag     <= '0;
            r_wrap    <= 1'b0;
            r_sel     <= 1'b0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_mag     <= w_mag_next;
            r_wrap    <= w_wrap_next;
            r_sel     <= w_sel_next;
            r_scratch <= w_scratch_next;
            r_cnt     <= w_cnt_next;
            r_bcd     <= w_bcd_next;
            r_ovf     <= w_ovf_next;
            r_unf     <= w_unf_next;
            r_busy    <= (w_state_next != StIdle);
            r_valid   <= (w_state_next == StDone);
        end
    end

    assign o_busy  = r_busy;
    assign o_valid = r_valid;
    assign o_bcd   = r_bcd;
    assign o_ovf   = r_ovf;
    assign o_unf   = r_unf;

endmodule

// File: tb/tb_count_bcd_reader.sv
// Scenario-driven bench: expected results are queued at launch and checked
// against every VALID pulse; timing is checked inline by each scenario.
module tb_count_bcd_reader;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic [18:0] cnt_in;
    logic        start;
    logic        busy;
    logic        valid;
    logic [23:0] bcd;
    logic        ovf;
    logic        unf;

    typedef struct packed {
        logic [23:0] bcd;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    count_bcd_reader dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sel    (sel),
        .i_cnt_in (cnt_in),
        .i_start  (start),
        .o_busy   (busy),
        .o_valid  (valid),
        .o_bcd    (bcd),
        .o_ovf    (ovf),
        .o_unf    (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [18:0] w, input logic s);
        exp_t e;
        e.bcd = to_bcd(int'(w[17:0]));
        e.ovf = ~s & w[18];
        e.unf = s & w[18];
        return e;
    endfunction

    // Scoreboard consumer: every VALID pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            exp_t e;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_valid: got bcd=%h ovf=%b unf=%b, required no pulse",
                         bcd, ovf, unf);
            end else begin
                e = sb_q.pop_front();
                if ({bcd, ovf, unf} !== {e.bcd, e.ovf, e.unf}) begin
                    n_errors++;
                    $display("FAIL result: got bcd=%h ovf=%b unf=%b, required bcd=%h ovf=%b unf=%b",
                             bcd, ovf, unf, e.bcd, e.ovf, e.unf);
                end
            end
            n_checks++;
            if ((ovf & unf) !== 1'b0) begin
                n_errors++;
                $display("FAIL flag_exclusive: got ovf=%b unf=%b, required not both 1", ovf, unf);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle START; returns 1 time unit after the capture edge E0.
    task automatic launch(input logic [18:0] w, input logic s);
        cnt_in = w;
        sel    = s;
        start  = 1'b1;
        sb_q.push_back(model(w, s));
        step(1);
        start  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        sel   = 1'b0;
        cnt_in = '0;
        step(3);
        n_checks++;
        if ({busy, valid, bcd, ovf, unf} !== 28'd0) begin
            n_errors++;
            $display("FAIL reset_state: got busy=%b valid=%b bcd=%h ovf=%b unf=%b, required all 0",
                     busy, valid, bcd, ovf, unf);
        end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_basic;
        launch(19'd123456, 1'b0);
        n_checks++;
        if ({busy, valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL basic_e0: got busy=%b valid=%b, required busy=1 valid=0", busy, valid);
        end
        for (int k = 1; k <= 19; k++) begin
            step(1);
            if (k == 3) begin
                cnt_in = 19'd777;
                sel    = 1'b1;
            end
            n_checks++;
            if ({busy, valid} !== {k <= 18, k == 18}) begin
                n_errors++;
                $display("FAIL basic_timing E%0d: got busy=%b valid=%b, required busy=%b valid=%b",
                         k, busy, valid, k <= 18, k == 18);
            end
        end
    endtask

    task automatic test_max_zero;
        launch(19'h3FFFF, 1'b1);
        step(19);
        step(5);
        n_checks++;
        if ({bcd, ovf, unf} !== {24'h262143, 2'b00}) begin
            n_errors++;
            $display("FAIL hold_result: got bcd=%h ovf=%b unf=%b, required bcd=262143 ovf=0 unf=0",
                     bcd, ovf, unf);
        end
        launch(19'd0, 1'b0);
        step(19);
    endtask

    task automatic test_flags;
        launch(19'h40000, 1'b0);
        step(19);
        launch(19'h40000, 1'b1);
        step(19);
        launch(19'd90817 | 19'h40000, 1'b0);
        step(19);
    endtask

    task automatic test_back_to_back;
        cnt_in = 19'd1234;
        sel    = 1'b0;
        start  = 1'b1;
        sb_q.push_back(model(19'd1234, 1'b0));
        step(1);
        for (int k = 1; k <= 38; k++) begin
            step(1);
            if (k == 5) begin
                cnt_in = 19'd999;
                sb_q.push_back(model(19'd999, 1'b0));
            end
            if (k == 19) start = 1'b0;
            n_checks++;
            if ({busy, valid} !== {k <= 37, (k == 18) || (k == 37)}) begin
                n_errors++;
                $display("FAIL b2b_timing E%0d: got busy=%b valid=%b, required busy=%b valid=%b",
                         k, busy, valid, k <= 37, (k == 18) || (k == 37));
            end
        end
    endtask

    task automatic test_abort;
        int pulses;
        launch(19'd42, 1'b0);
        step(19);
        cnt_in = 19'd7;
        sel    = 1'b0;
        start  = 1'b1;
        step(1);
        start  = 1'b0;
        step(8);
        rst_n = 1'b0;
        step(1);
        n_checks++;
        if ({busy, valid, bcd, ovf, unf} !== 28'd0) begin
            n_errors++;
            $display("FAIL abort_state: got busy=%b valid=%b bcd=%h ovf=%b unf=%b, required all 0",
                     busy, valid, bcd, ovf, unf);
        end
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            step(1);
            if (valid === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_errors++;
            $display("FAIL abort_no_valid: got %0d pulses, required 0", pulses);
        end
    endtask

    task automatic test_reset_start;
        rst_n  = 1'b0;
        start  = 1'b1;
        cnt_in = 19'd5;
        step(1);
        n_checks++;
        if ({busy, valid} !== 2'b00) begin
            n_errors++;
            $display("FAIL rst_over_start: got busy=%b valid=%b, required 0 0", busy, valid);
        end
        start = 1'b0;
        rst_n = 1'b1;
        step(1);
        launch(19'd86420 | 19'h40000, 1'b1);
        step(17);
        n_checks++;
        if (valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rs_early_valid: got valid=%b at E17, required 0", valid);
        end
        step(1);
        n_checks++;
        if ({busy, valid} !== 2'b11) begin
            n_errors++;
            $display("FAIL rs_done E18: got busy=%b valid=%b, required 1 1", busy, valid);
        end
        step(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_zero();
        test_flags();
        test_back_to_back();
        test_abort();
        test_reset_start();
        step(2);
        n_checks++;
        if (sb_q.size() !== 0) begin
            n_errors++;
            $display("FAIL missing_results: got %0d pending, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
